// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and elaboration checks for regfile_n.
// Holds the swap FSM state enum and the NREGS power-of-two rule.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP1 = 2'd1,
    SWAP2 = 2'd2
  } state_e;

  // NREGS must be a power of two and at least 2
  function automatic bit nregs_ok(int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_n_tx.sv
// regfile_n_tx: tri-state bus transmitter.
// Ports: a_i data, noe_i active-low enable, y_o bus (Z when disabled).
module regfile_n_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             noe_i,
  output tri   [WIDTH-1:0] y_o
);

  assign y_o = noe_i ? {WIDTH{1'bz}} : a_i;

endmodule

// File: rtl/regfile_n.sv
// regfile_n: NREGS x WIDTH register file with inc/dec and 2-cycle swap.
// Ports: i_clk, i_nreset (sync, low), i_bus/o_bus data bus,
//   o_aluA/o_aluB operands via i_selA/i_selB, i_wrAddr target,
//   i_ctrlNWE/Inc/Dec/BusNOE/Swap controls, o_busy, o_zeroA.
module regfile_n
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_nreset,
  input  logic [WIDTH-1:0] i_bus,
  output tri   [WIDTH-1:0] o_bus,
  output logic [WIDTH-1:0] o_aluA,
  output logic [WIDTH-1:0] o_aluB,
  input  logic [AW-1:0]    i_selA,
  input  logic [AW-1:0]    i_selB,
  input  logic [AW-1:0]    i_wrAddr,
  input  logic             i_ctrlNWE,
  input  logic             i_ctrlInc,
  input  logic             i_ctrlDec,
  input  logic             i_ctrlBusNOE,
  input  logic             i_ctrlSwap,
  output logic             o_busy,
  output logic             o_zeroA
);

  localparam bit NREGS_OK = nregs_ok(NREGS);

  if (!NREGS_OK) begin : g_bad_nregs
    $error("regfile_n: NREGS must be a power of two >= 2");
  end

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] tmp_q;
  logic [AW-1:0]    sa_q;
  logic [AW-1:0]    sb_q;
  state_e           state_q;
  logic             busy_q;

  assign o_aluA  = regs_q[i_selA];
  assign o_aluB  = regs_q[i_selB];
  assign o_zeroA = (o_aluA == '0);
  assign o_busy  = busy_q;

  regfile_n_tx #(
    .WIDTH (WIDTH)
  ) u_tx (
    .a_i   (regs_q[i_wrAddr]),
    .noe_i (i_ctrlBusNOE),
    .y_o   (o_bus)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      tmp_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // a swap request wins over any write in the same cycle
          if (i_ctrlSwap) begin
            sa_q    <= i_selA;
            sb_q    <= i_selB;
            tmp_q   <= regs_q[i_selA];
            state_q <= SWAP1;
            busy_q  <= 1'b1;
          end else if (!i_ctrlNWE) begin
            regs_q[i_wrAddr] <= i_bus;
          end else if (i_ctrlInc && !i_ctrlDec) begin
            regs_q[i_wrAddr] <= regs_q[i_wrAddr] + WIDTH'(1);
          end else if (i_ctrlDec && !i_ctrlInc) begin
            regs_q[i_wrAddr] <= regs_q[i_wrAddr] - WIDTH'(1);
          end
        end
        SWAP1: begin
          regs_q[sa_q] <= regs_q[sb_q];
          state_q      <= SWAP2;
        end
        SWAP2: begin
          regs_q[sb_q] <= tmp_q;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n: directed and random checks of regfile_n.
// Reference model holds register values as an array and swaps as one exchange.
module tb_regfile_n;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] bus_i;
  wire  [7:0] bus;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [1:0] selA;
  logic [1:0] selB;
  logic [1:0] wr;
  logic       nwe;
  logic       inc;
  logic       dec;
  logic       noe;
  logic       swp;
  logic       busy;
  logic       zeroA;

  int total = 0;
  int bad   = 0;

  logic [7:0] m [4];
  int         cnt;
  logic [1:0] msa;
  logic [1:0] msb;

  always #5 clk = ~clk;

  regfile_n #(
    .WIDTH (8),
    .NREGS (4)
  ) dut (
    .i_clk        (clk),
    .i_nreset     (nrst),
    .i_bus        (bus_i),
    .o_bus        (bus),
    .o_aluA       (aluA),
    .o_aluB       (aluB),
    .i_selA       (selA),
    .i_selB       (selB),
    .i_wrAddr     (wr),
    .i_ctrlNWE    (nwe),
    .i_ctrlInc    (inc),
    .i_ctrlDec    (dec),
    .i_ctrlBusNOE (noe),
    .i_ctrlSwap   (swp),
    .o_busy       (busy),
    .o_zeroA      (zeroA)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, updating the model from the pre-edge inputs
  task automatic cyc();
    logic [7:0] t;
    if (!nrst) begin
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      cnt = 0;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        t      = m[msa];
        m[msa] = m[msb];
        m[msb] = t;
      end
    end else if (swp) begin
      msa = selA;
      msb = selB;
      cnt = 2;
    end else if (!nwe) begin
      m[wr] = bus_i;
    end else if (inc && !dec) begin
      m[wr] = m[wr] + 8'd1;
    end else if (dec && !inc) begin
      m[wr] = m[wr] - 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    nwe = 1'b1;
    inc = 1'b0;
    dec = 1'b0;
    swp = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    quiet();
    wr    = a;
    bus_i = d;
    nwe   = 1'b0;
    cyc();
    nwe   = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(cnt > 0));
    if (cnt == 0) begin
      chk({tag, "_A"}, 32'(aluA), 32'(m[selA]));
      chk({tag, "_B"}, 32'(aluB), 32'(m[selB]));
      chk({tag, "_zA"}, 32'(zeroA), 32'(m[selA] == 8'h00));
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      selA = 2'(i);
      selB = 2'(3 - i);
      #1;
      check_state(tag);
    end
  endtask

  initial begin
    nrst  = 1'b0;
    bus_i = 8'h00;
    selA  = 2'd0;
    selB  = 2'd0;
    wr    = 2'd0;
    noe   = 1'b1;
    cnt   = 0;
    msa   = 2'd0;
    msb   = 2'd0;
    for (int i = 0; i < 4; i++) m[i] = 8'hXX;
    quiet();

    // reset, then bus write of reg2
    cyc();
    nrst = 1'b1;
    read_all("rst");
    selA = 2'd2;
    #1;
    chk("rst_zeroA", 32'(zeroA), 32'd1);
    wr_reg(2'd2, 8'hA5);
    selA = 2'd2;
    noe  = 1'b0;
    #1;
    chk("wr_aluA", 32'(aluA), 32'h0A5);
    chk("wr_zeroA", 32'(zeroA), 32'd0);
    total++;
    assert (bus === 8'hA5) else begin
      bad++;
      $error("FAIL bus_drive observed=%h expected=a5", bus);
    end
    noe = 1'b1;
    #1;
    total++;
    assert (bus === 8'hzz) else begin
      bad++;
      $error("FAIL bus_hiz observed=%h expected=zz", bus);
    end

    // inc/dec wrap on reg1
    wr_reg(2'd1, 8'hFF);
    selA = 2'd1;
    inc  = 1'b1;
    cyc();
    inc  = 1'b0;
    chk("inc_wrap", 32'(aluA), 32'h000);
    dec  = 1'b1;
    cyc();
    chk("dec_wrap", 32'(aluA), 32'h0FF);
    cyc();
    chk("dec_fe", 32'(aluA), 32'h0FE);
    dec  = 1'b0;

    // write beats inc; inc+dec is a no-op
    selA  = 2'd0;
    wr    = 2'd0;
    bus_i = 8'h10;
    nwe   = 1'b0;
    inc   = 1'b1;
    cyc();
    chk("prio_wr", 32'(aluA), 32'h010);
    nwe   = 1'b1;
    dec   = 1'b1;
    cyc();
    chk("prio_incdec", 32'(aluA), 32'h010);
    quiet();

    // swap reg0/reg3 with writes attempted while busy
    wr_reg(2'd0, 8'h11);
    wr_reg(2'd3, 8'h33);
    selA = 2'd0;
    selB = 2'd3;
    swp  = 1'b1;
    cyc();
    swp   = 1'b0;
    nwe   = 1'b0;
    bus_i = 8'hEE;
    wr    = 2'd0;
    chk("swap_busy1", 32'(busy), 32'd1);
    cyc();
    chk("swap_busy2", 32'(busy), 32'd1);
    cyc();
    nwe = 1'b1;
    chk("swap_done", 32'(busy), 32'd0);
    chk("swap_r0", 32'(aluA), 32'h033);
    chk("swap_r3", 32'(aluB), 32'h011);
    check_state("swap");

    // self-swap with a dropped second request
    wr_reg(2'd2, 8'h5A);
    selA = 2'd2;
    selB = 2'd2;
    swp  = 1'b1;
    cyc();
    chk("self_busy1", 32'(busy), 32'd1);
    cyc();
    chk("self_busy2", 32'(busy), 32'd1);
    swp  = 1'b0;
    cyc();
    chk("self_done", 32'(busy), 32'd0);
    cyc();
    chk("self_nobusy", 32'(busy), 32'd0);
    chk("self_val", 32'(aluA), 32'h05A);

    // reset in SWAP1
    selA = 2'd2;
    selB = 2'd0;
    swp  = 1'b1;
    cyc();
    swp  = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    chk("mid_idle", 32'(busy), 32'd0);
    read_all("mid");
    cyc();
    chk("mid_stay", 32'(busy), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      nrst  = ($urandom_range(0, 59) != 0);
      selA  = 2'($urandom);
      selB  = 2'($urandom);
      wr    = 2'($urandom);
      bus_i = 8'($urandom);
      nwe   = ($urandom_range(0, 2) != 0);
      inc   = ($urandom_range(0, 2) == 0);
      dec   = ($urandom_range(0, 2) == 0);
      swp   = ($urandom_range(0, 5) == 0);
      noe   = 1'($urandom);
      cyc();
      check_state("rnd");
      if (!noe && cnt == 0) begin
        total++;
        assert (bus === m[wr]) else begin
          bad++;
          $error("FAIL rnd_bus observed=%h expected=%h", bus, m[wr]);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
